// File: rtl/uart_rx_fifo_if.sv
// UART receive FIFO bus: frame input from the RX engine and host read side.
// The master drives frames and reads; the slave is the FIFO.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              rx_done;
    logic [7:0]        rx_data;
    logic              parity_error;
    logic [1:0]        data_bit_num;
    logic              rd_en;
    logic              ovf_clr;
    logic [7:0]        rd_data;
    logic              rd_perr;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              rts_n;

    modport master (
        output rx_done, rx_data, parity_error, data_bit_num,
        output rd_en, ovf_clr,
        input  rd_data, rd_perr, rd_valid, empty, full,
        input  count, overflow, rts_n
    );

    modport slave (
        input  rx_done, rx_data, parity_error, data_bit_num,
        input  rd_en, ovf_clr,
        output rd_data, rd_perr, rd_valid, empty, full,
        output count, overflow, rts_n
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures frames on rx_done rising edge into a
// circular FIFO with registered read data, rts_n threshold and sticky overflow.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);
    localparam logic [ADDR_W:0]   FULL_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_C = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic                rx_done_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_d;
    logic [8:0]          mem_q [DEPTH];
    logic [7:0]          rd_data_q;
    logic                rd_perr_q;
    logic                rd_valid_q;
    logic                overflow_q;
    logic                rts_n_q;

    logic                push;
    logic                pop;
    logic                wr_en;
    logic                empty;
    logic                full;
    logic [7:0]          data_m;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_C);
    assign push  = bus.rx_done & ~rx_done_q;
    assign pop   = bus.rd_en & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    assign wr_en = push & (~full | pop);

    always_comb begin
        data_m = bus.rx_data;
        unique case (bus.data_bit_num)
            2'b00: data_m = bus.rx_data & 8'h1F;
            2'b01: data_m = bus.rx_data & 8'h3F;
            2'b10: data_m = bus.rx_data & 8'h7F;
            2'b11: data_m = bus.rx_data;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (wr_en & ~pop)
            count_d = count_q + CNT_ONE;
        else if (pop & ~wr_en)
            count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= {bus.parity_error, data_m};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_done_q  <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_perr_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            rts_n_q    <= 1'b0;
        end else begin
            rx_done_q  <= bus.rx_done;
            count_q    <= count_d;
            rts_n_q    <= (count_d >= AFULL_C);
            rd_valid_q <= pop;
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                rd_data_q <= mem_q[rd_ptr_q][7:0];
                rd_perr_q <= mem_q[rd_ptr_q][8];
            end
            if (push & ~wr_en)
                overflow_q <= 1'b1;
            else if (bus.ovf_clr)
                overflow_q <= 1'b0;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_perr  = rd_perr_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.rts_n    = rts_n_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    logic [8:0] mq[$];
    logic       m_ovf;
    logic [7:0] m_rd_data;
    logic       m_rd_perr;
    logic       m_rd_valid;
    logic       m_rx_prev;

    uart_rx_fifo_if #(.ADDR_W(4)) bus ();

    uart_rx_fifo #(
        .DEPTH(DEPTH),
        .ADDR_W(4),
        .AFULL_LVL(AFULL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_all();
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("rts_n", 32'(bus.rts_n), 32'(mq.size() >= AFULL));
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
        chk("rd_data", 32'(bus.rd_data), 32'(m_rd_data));
        chk("rd_perr", 32'(bus.rd_perr), 32'(m_rd_perr));
    endtask

    task automatic step(input logic rxd, input logic [7:0] d,
                        input logic pe, input logic [1:0] dbn,
                        input logic rd, input logic oc);
        logic push;
        logic pop;
        logic [8:0] head;
        int mask;
        bus.rx_done      = rxd;
        bus.rx_data      = d;
        bus.parity_error = pe;
        bus.data_bit_num = dbn;
        bus.rd_en        = rd;
        bus.ovf_clr      = oc;
        @(posedge clk);
        #1;
        push = rxd && !m_rx_prev;
        m_rx_prev = rxd;
        pop = rd && (mq.size() != 0);
        m_rd_valid = pop;
        if (pop) begin
            head = mq.pop_front();
            m_rd_data = head[7:0];
            m_rd_perr = head[8];
        end
        if (push) begin
            if (mq.size() < DEPTH) begin
                mask = (1 << (5 + int'(dbn))) - 1;
                mq.push_back({pe, 8'(int'(d) & mask)});
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (!(push && !pop && mq.size() == DEPTH && !(mq.size() < DEPTH))
            && oc && !(push && mq.size() == DEPTH && !pop && m_ovf))
            m_ovf = 1'b0;
        chk_all();
    endtask

    task automatic frame(input logic [7:0] d, input logic pe,
                         input logic [1:0] dbn, input logic rd);
        step(1'b0, 8'h00, 1'b0, dbn, 1'b0, 1'b0);
        step(1'b1, d, pe, dbn, rd, 1'b0);
    endtask

    task automatic idle(input logic rd, input logic oc);
        step(1'b1, 8'h00, 1'b0, 2'b11, rd, oc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.rx_done = 1'b1;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        #1;
        mq.delete();
        m_ovf      = 1'b0;
        m_rd_data  = 8'h00;
        m_rd_perr  = 1'b0;
        m_rd_valid = 1'b0;
        m_rx_prev  = 1'b1;
        chk_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        n_chk = 0;
        n_pass = 0;
        bus.rx_data = 8'h00;
        bus.parity_error = 1'b0;
        bus.data_bit_num = 2'b11;
        do_reset();

        // 8-bit frames read back in order
        frame(8'hA5, 1'b0, 2'b11, 1'b0);
        frame(8'h3C, 1'b0, 2'b11, 1'b0);
        chk("t1_count", 32'(bus.count), 32'd2);
        idle(1'b1, 1'b0);
        chk("t1_first", 32'(bus.rd_data), 32'hA5);
        idle(1'b1, 1'b0);
        chk("t1_second", 32'(bus.rd_data), 32'h3C);
        idle(1'b0, 1'b0);
        chk("t1_empty", 32'(bus.empty), 32'd1);

        // 5-bit masking with parity error
        frame(8'hFF, 1'b1, 2'b00, 1'b0);
        idle(1'b1, 1'b0);
        chk("t2_data", 32'(bus.rd_data), 32'h1F);
        chk("t2_perr", 32'(bus.rd_perr), 32'd1);

        // rd_en while empty
        idle(1'b1, 1'b0);
        chk("t6_novalid", 32'(bus.rd_valid), 32'd0);
        chk("t6_hold", 32'(bus.rd_data), 32'h1F);

        // threshold
        for (int i = 0; i < 11; i++)
            frame(8'(i + 8'h40), 1'b0, 2'b11, 1'b0);
        chk("t4_rts11", 32'(bus.rts_n), 32'd0);
        frame(8'h4B, 1'b0, 2'b11, 1'b0);
        chk("t4_rts12", 32'(bus.rts_n), 32'd1);
        idle(1'b1, 1'b0);
        chk("t4_rts_pop", 32'(bus.rts_n), 32'd0);

        // overflow, clear, push+pop while full
        do_reset();
        for (int i = 1; i <= 17; i++)
            frame(8'(i), 1'b0, 2'b11, 1'b0);
        chk("t3_full", 32'(bus.full), 32'd1);
        chk("t3_count", 32'(bus.count), 32'd16);
        chk("t3_ovf", 32'(bus.overflow), 32'd1);
        idle(1'b0, 1'b1);
        chk("t3_ovf_clr", 32'(bus.overflow), 32'd0);
        frame(8'hEE, 1'b0, 2'b11, 1'b1);
        chk("t5_count", 32'(bus.count), 32'd16);
        chk("t5_ovf", 32'(bus.overflow), 32'd0);
        chk("t5_head", 32'(bus.rd_data), 32'h01);
        for (int i = 0; i < 16; i++)
            idle(1'b1, 1'b0);
        chk("t5_last", 32'(bus.rd_data), 32'hEE);

        // push+pop with a single entry returns the old head
        frame(8'h11, 1'b0, 2'b11, 1'b0);
        frame(8'h22, 1'b0, 2'b11, 1'b1);
        chk("c1_head", 32'(bus.rd_data), 32'h11);
        chk("c1_count", 32'(bus.count), 32'd1);

        // reset mid-operation
        for (int i = 0; i < 4; i++)
            frame(8'(i), 1'b1, 2'b10, 1'b0);
        chk("r_count5", 32'(bus.count), 32'd5);
        do_reset();
        chk("r_empty", 32'(bus.empty), 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic rxd;
            logic rd;
            rxd = bus.rx_done;
            if ($urandom_range(0, 2) == 0)
                rxd = ~rxd;
            if (i < 1500)
                rd = ($urandom_range(0, 7) == 0);
            else
                rd = ($urandom_range(0, 1) == 0);
            step(rxd, 8'($urandom), 1'($urandom), 2'($urandom), rd,
                 ($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
